// File: rtl/foreground_pkg.sv
// rtl/foreground_pkg.sv - shared constants, FSM state type and hit test for the foreground scheduler
package foreground_pkg;

    localparam int NUM_OBJECTS = 64;
    localparam int MAX_SLOTS   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fg_state_t;

    // 9-bit compare so objects near the bottom (Y >= 0xF8) never wrap onto the top lines
    function automatic logic hit_test(input logic [7:0] y, input logic [7:0] ly);
        return (y <= ly) && ({1'b0, ly} < ({1'b0, y} + 9'd8));
    endfunction

endpackage

// File: rtl/foreground_scheduler_m_if.sv
// rtl/foreground_scheduler_m_if.sv - OBM read port and line-buffer slot write port
interface foreground_scheduler_m_if;

    logic [5:0] obm_addr;
    logic [7:0] obm_y;
    logic       slot_we;
    logic [2:0] slot_idx;
    logic [5:0] slot_obma;
    logic [2:0] slot_row;

    modport master (
        output obm_addr,
        input  obm_y,
        output slot_we,
        output slot_idx,
        output slot_obma,
        output slot_row
    );

    modport slave (
        input  obm_addr,
        output obm_y,
        input  slot_we,
        input  slot_idx,
        input  slot_obma,
        input  slot_row
    );

endinterface

// File: rtl/foreground_scheduler_m.sv
// rtl/foreground_scheduler_m.sv - per-scanline object evaluator filling up to MAX_SLOTS line-buffer slots
module foreground_scheduler_m #(
    parameter int NUM_OBJECTS = foreground_pkg::NUM_OBJECTS,
    parameter int MAX_SLOTS   = foreground_pkg::MAX_SLOTS
) (
    input  logic                       clk_12_5875,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 line_y,
    foreground_scheduler_m_if.master   bus,
    output logic [3:0]                 slot_count,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    import foreground_pkg::*;

    fg_state_t  r_state;
    fg_state_t  w_state_nxt;

    logic [7:0] r_ly;
    logic [5:0] r_addr;
    logic [5:0] r_cmp_idx;
    logic       r_cmp_valid;
    logic [3:0] r_count;
    logic       r_overflow;
    logic       r_slot_we;
    logic [2:0] r_slot_idx;
    logic [5:0] r_slot_obma;
    logic [2:0] r_slot_row;

    logic       w_start;
    logic       w_hit;
    logic       w_room;
    logic       w_write;
    logic       w_ovf;
    logic       w_last;
    logic       w_adv;
    logic [7:0] w_diff;

    assign w_start = start && (r_state == IDLE);
    // Once overflow is flagged, any compare still in the pipe is dropped
    assign w_hit   = r_cmp_valid && !r_overflow && hit_test(bus.obm_y, r_ly);
    assign w_room  = r_count < 4'(MAX_SLOTS);
    assign w_write = w_hit && w_room;
    assign w_ovf   = w_hit && !w_room;
    assign w_last  = (r_addr == 6'(NUM_OBJECTS - 1));
    assign w_adv   = (r_state == SCAN) && !w_last && !r_overflow && !w_ovf;
    assign w_diff  = r_ly - bus.obm_y;

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SCAN;
            SCAN:    if (r_overflow || w_last) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            r_ly        <= 8'd0;
            r_addr      <= 6'd0;
            r_cmp_idx   <= 6'd0;
            r_cmp_valid <= 1'b0;
            r_count     <= 4'd0;
            r_overflow  <= 1'b0;
            r_slot_we   <= 1'b0;
            r_slot_idx  <= 3'd0;
            r_slot_obma <= 6'd0;
            r_slot_row  <= 3'd0;
        end else begin
            // obm_y returns one cycle after the address, so track which index it belongs to
            r_cmp_valid <= (r_state == SCAN);
            r_cmp_idx   <= r_addr;
            r_slot_we   <= w_write;

            if (w_adv) begin
                r_addr <= r_addr + 6'd1;
            end

            if (w_write) begin
                r_count     <= r_count + 4'd1;
                r_slot_idx  <= r_count[2:0];
                r_slot_obma <= r_cmp_idx;
                r_slot_row  <= w_diff[2:0];
            end

            if (w_ovf) begin
                r_overflow <= 1'b1;
            end

            if (w_start) begin
                r_ly       <= line_y;
                r_addr     <= 6'd0;
                r_count    <= 4'd0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.obm_addr  = r_addr;
    assign bus.slot_we   = r_slot_we;
    assign bus.slot_idx  = r_slot_idx;
    assign bus.slot_obma = r_slot_obma;
    assign bus.slot_row  = r_slot_row;

    assign slot_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule

// File: tb/tb_foreground_scheduler_m.sv
// tb/tb_foreground_scheduler_m.sv - directed-vector bench for foreground_scheduler_m
module tb_foreground_scheduler_m;

    logic       clk_12_5875 = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] line_y = 8'd0;
    logic [3:0] slot_count;
    logic       overflow;
    logic       busy;
    logic       done;

    foreground_scheduler_m_if bus ();

    foreground_scheduler_m dut (
        .clk_12_5875 (clk_12_5875),
        .rst         (rst),
        .start       (start),
        .line_y      (line_y),
        .bus         (bus),
        .slot_count  (slot_count),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_12_5875 = ~clk_12_5875;

    logic [7:0] obm_mem [64];
    always @(posedge clk_12_5875) bus.obm_y <= obm_mem[bus.obm_addr];

    int cyc = 0;
    always @(posedge clk_12_5875) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int t0 = 0;
    int w_n = 0;
    int w_rel [16];
    int w_idx [16];
    int w_obma [16];
    int w_row [16];
    int done_n = 0;
    int done_rel = -1;
    logic [5:0] addr_at1;
    logic [5:0] addr_at34;

    always @(negedge clk_12_5875) begin
        if (bus.slot_we) begin
            if (w_n < 16) begin
                w_rel[w_n]  = cyc - t0;
                w_idx[w_n]  = int'(bus.slot_idx);
                w_obma[w_n] = int'(bus.slot_obma);
                w_row[w_n]  = int'(bus.slot_row);
            end
            w_n++;
        end
        if (done) begin
            done_n++;
            done_rel = cyc - t0;
        end
        if (cyc - t0 == 1)  addr_at1  = bus.obm_addr;
        if (cyc - t0 == 34) addr_at34 = bus.obm_addr;
    end

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 64; i++) obm_mem[i] = v;
    endtask

    task automatic clear_log();
        w_n      = 0;
        done_n   = 0;
        done_rel = -1;
        t0       = cyc;
    endtask

    task automatic begin_scan(input logic [7:0] ly);
        @(negedge clk_12_5875);
        clear_log();
        start  = 1'b1;
        line_y = ly;
        @(negedge clk_12_5875);
        start  = 1'b0;
        line_y = 8'h00;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_n == 0 && k < 200) begin
            @(negedge clk_12_5875);
            k++;
        end
        repeat (2) @(negedge clk_12_5875);
        chk_vec("done_seen", done_n, 1);
    endtask

    initial begin
        int er [3];
        fill(8'hFF);
        repeat (3) @(negedge clk_12_5875);
        chk_vec("rst_slot_we", bus.slot_we, 0);
        chk_vec("rst_slot_idx", bus.slot_idx, 0);
        chk_vec("rst_slot_obma", bus.slot_obma, 0);
        chk_vec("rst_slot_row", bus.slot_row, 0);
        chk_vec("rst_slot_count", slot_count, 0);
        chk_vec("rst_overflow", overflow, 0);
        chk_vec("rst_busy", busy, 0);
        chk_vec("rst_done", done, 0);
        chk_vec("rst_obm_addr", bus.obm_addr, 0);
        rst = 1'b0;

        // all objects off-screen
        begin_scan(8'h10);
        chk_vec("empty_busy", busy, 1);
        wait_done();
        chk_vec("empty_writes", w_n, 0);
        chk_vec("empty_count", slot_count, 0);
        chk_vec("empty_ovf", overflow, 0);
        chk_vec("empty_done_t", done_rel, 66);
        chk_vec("addr_t1", addr_at1, 0);
        chk_vec("addr_t34", addr_at34, 33);
        chk_vec("addr_hold", bus.obm_addr, 63);
        chk_vec("idle_busy", busy, 0);

        // three sparse hits
        fill(8'hFF);
        obm_mem[3] = 8'h0C; obm_mem[9] = 8'h0C; obm_mem[40] = 8'h0C;
        begin_scan(8'h10);
        wait_done();
        er = '{6, 12, 43};
        chk_vec("sparse_writes", w_n, 3);
        for (int i = 0; i < 3; i++) begin
            chk_vec("sparse_t", w_rel[i], er[i]);
            chk_vec("sparse_idx", w_idx[i], i);
            chk_vec("sparse_row", w_row[i], 4);
        end
        chk_vec("sparse_obma0", w_obma[0], 3);
        chk_vec("sparse_obma1", w_obma[1], 9);
        chk_vec("sparse_obma2", w_obma[2], 40);
        chk_vec("sparse_count", slot_count, 3);
        chk_vec("sparse_ovf", overflow, 0);
        chk_vec("sparse_done_t", done_rel, 66);

        // ten hits: eight slots, then overflow and early finish
        fill(8'hFF);
        for (int i = 0; i < 10; i++) obm_mem[i] = 8'h20;
        begin_scan(8'h27);
        wait_done();
        chk_vec("ovf_writes", w_n, 8);
        for (int i = 0; i < 8; i++) begin
            chk_vec("ovf_t", w_rel[i], 3 + i);
            chk_vec("ovf_idx", w_idx[i], i);
            chk_vec("ovf_obma", w_obma[i], i);
            chk_vec("ovf_row", w_row[i], 7);
        end
        chk_vec("ovf_done_t", done_rel, 13);
        repeat (3) @(negedge clk_12_5875);
        chk_vec("ovf_count_hold", slot_count, 8);
        chk_vec("ovf_flag_hold", overflow, 1);
        chk_vec("ovf_done_once", done_n, 1);

        // row boundaries at line 8
        fill(8'hFF);
        obm_mem[5] = 8'h08; obm_mem[6] = 8'h01; obm_mem[7] = 8'h00;
        begin_scan(8'h08);
        wait_done();
        chk_vec("bnd_writes", w_n, 2);
        chk_vec("bnd_obma0", w_obma[0], 5);
        chk_vec("bnd_row0", w_row[0], 0);
        chk_vec("bnd_obma1", w_obma[1], 6);
        chk_vec("bnd_row1", w_row[1], 7);
        chk_vec("bnd_count", slot_count, 2);

        // bottom-edge object must not wrap onto line 0
        fill(8'hFF);
        obm_mem[5] = 8'hF9;
        begin_scan(8'h00);
        wait_done();
        chk_vec("wrap_writes", w_n, 0);
        chk_vec("wrap_count", slot_count, 0);

        // reset mid-scan
        fill(8'hFF);
        obm_mem[3] = 8'h0C; obm_mem[9] = 8'h0C; obm_mem[40] = 8'h0C;
        begin_scan(8'h10);
        repeat (19) @(negedge clk_12_5875);
        rst = 1'b1;
        @(negedge clk_12_5875);
        rst = 1'b0;
        chk_vec("abort_busy", busy, 0);
        chk_vec("abort_count", slot_count, 0);
        chk_vec("abort_we", bus.slot_we, 0);
        repeat (60) @(negedge clk_12_5875);
        chk_vec("abort_writes", w_n, 2);
        chk_vec("abort_no_done", done_n, 0);

        // reset beats start; start right after reset is accepted
        @(negedge clk_12_5875);
        rst = 1'b1; start = 1'b1; line_y = 8'h10;
        @(negedge clk_12_5875);
        rst = 1'b0;
        chk_vec("rst_prio_busy", busy, 0);
        clear_log();
        @(negedge clk_12_5875);
        start = 1'b0; line_y = 8'h00;
        chk_vec("post_rst_busy", busy, 1);
        wait_done();
        chk_vec("post_rst_writes", w_n, 3);
        chk_vec("post_rst_done_t", done_rel, 66);

        // start held high through the scan
        @(negedge clk_12_5875);
        clear_log();
        start = 1'b1; line_y = 8'h10;
        @(negedge clk_12_5875);
        line_y = 8'h00;
        repeat (29) @(negedge clk_12_5875);
        start = 1'b0;
        wait_done();
        chk_vec("held_writes", w_n, 3);
        chk_vec("held_t2", w_rel[2], 43);
        chk_vec("held_row", w_row[2], 4);
        chk_vec("held_done_t", done_rel, 66);
        chk_vec("held_done_once", done_n, 1);
        chk_vec("held_count", slot_count, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/foreground_scheduler_m.md
FOREGROUND_SCHEDULER_M -- requirements
Module: foreground_scheduler_m

Interface
REQ-001 Parameter NUM_OBJECTS, default 64, gives the number of OBM objects scanned per line.
REQ-002 Parameter MAX_SLOTS, default 8, gives the number of per-line object slots.
REQ-003 Port clk_12_5875, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: one-cycle request to evaluate the next scanline; it is issued at hblank entry.
REQ-006 Port line_y, input, 8 bits: the scanline to evaluate; it SHALL be sampled only with an accepted start.
REQ-007 Port obm_addr, output, 6 bits: index of the object whose Y byte is being read.
REQ-008 Port obm_y, input, 8 bits: Y byte of the object at obm_addr, valid one cycle after obm_addr is driven.
REQ-009 Ports slot_we (1 bit), slot_idx (3 bits), slot_obma (6 bits) and slot_row (3 bits), outputs: write strobe, slot number, object index and row within the object for the line-buffer loader.
REQ-010 Port slot_count, output, 4 bits: number of slots written for the current line (0..MAX_SLOTS).
REQ-011 Port overflow, output, 1 bit: set when more than MAX_SLOTS objects hit the line.
REQ-012 Ports busy and done, outputs, 1 bit each: busy is high while scanning; done is a one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, SCAN, FLUSH and DONE.
REQ-014 start in IDLE (cycle T) SHALL latch line_y, clear slot_count and overflow, and enter SCAN at T+1.
REQ-015 start outside IDLE SHALL be ignored, with no effect on state or outputs.
REQ-016 In SCAN, obm_addr SHALL equal k at cycle T+1+k for k = 0..NUM_OBJECTS-1, and SCAN SHALL go to FLUSH after issuing index NUM_OBJECTS-1.
REQ-017 Hit test at cycle T+2+k: hit = (obm_y <= ly) && ({1'b0,ly} < {1'b0,obm_y} + 9'd8), computed in 9 bits with no wrap, so Y=0xF8..0xFF never hits lines 0..7.
REQ-018 A hit with slot_count < MAX_SLOTS SHALL assert slot_we at T+3+k with the following values, and slot_count SHALL increment in the same cycle:
  - slot_idx = slot_count;
  - slot_obma = k;
  - slot_row = (ly - obm_y)[2:0].
REQ-019 Slots SHALL be filled in ascending object index, so a lower index means a higher priority; this matches the foreground FFS priority.
REQ-020 On a hit with slot_count == MAX_SLOTS:
  - overflow SHALL be set;
  - slot_we SHALL NOT be asserted;
  - address issue SHALL stop and the FSM SHALL enter FLUSH;
  - the in-flight compare SHALL be discarded.
REQ-021 FLUSH SHALL last exactly one cycle, completing the last outstanding compare, then go to DONE.
REQ-022 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-023 With no overflow, done SHALL be at T+2+NUM_OBJECTS, which is cycle T+66 at the defaults.
REQ-024 busy SHALL be high in SCAN, FLUSH and DONE, and low in IDLE.
REQ-025 slot_count and overflow SHALL hold their values from done until the next accepted start.
REQ-026 slot_we SHALL be low in every cycle without a qualifying hit.
REQ-027 obm_addr SHALL hold its last value when not in SCAN.

Reset
REQ-028 rst SHALL force IDLE, and the following outputs SHALL reset to the values given:
  - slot_we = 0, slot_idx = 0, slot_obma = 0, slot_row = 0;
  - slot_count = 0, overflow = 0;
  - busy = 0, done = 0;
  - obm_addr = 0.
REQ-029 rst asserted mid-scan SHALL abort in the same edge: no further slot_we, no done pulse, and a new start is accepted on the first cycle after rst deasserts.
REQ-030 rst SHALL have priority over a simultaneous start.

Structure
REQ-031 foreground_pkg SHALL hold NUM_OBJECTS, MAX_SLOTS, the FSM state enum, and the 9-bit hit-test function.
REQ-032 No sub-module SHALL be used; the comparator and counters are inline, and the expected size is about 150-250 lines of RTL.

Verification
REQ-033 All Y bytes 0xFF, start with line_y=0x10: zero slot_we, slot_count=0, overflow=0, done at T+66.
REQ-034 Objects 3, 9 and 40 with Y=0x0C, start with line_y=0x10:
  - three writes at T+6, T+12 and T+43;
  - slot_obma 3, 9, 40; slot_idx 0, 1, 2; slot_row 4;
  - slot_count=3.
REQ-035 Objects 0..9 with Y=0x20, start with line_y=0x27:
  - slots 0..7 get objects 0..7 with row 7;
  - object 8 sets overflow and is not written;
  - done pulses early, at T+13.
REQ-036 Boundary cases, each with line_y=0x08:
  - Y=0x08 gives row 0;
  - Y=0x01 gives row 7;
  - Y=0x00 gives no hit;
  - Y=0xF9 with line_y=0x00 gives no hit (no wrap).
REQ-037 Reset and start handling:
  - rst asserted at T+20 during a scan with hits gives no further slot_we, no done, and slot_count=0;
  - start held during SCAN has no effect.
